norm_share_arbiter: RTL



---
 rtl/norm_share_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/norm_share_arbiter.sv
// Two-port round-robin arbiter feeding a shared two-stage normalizer.
// Results return a left-justified mantissa, leading-zero count and adjusted exponent.
module norm_share_arbiter #(
  parameter int EXP_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [31:0]      a_mant,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [31:0]      b_mant,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [TAG_W-1:0] b_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [4:0]       out_lz,
  output logic             out_zero,
  output logic             out_uflow
);

  function automatic logic [4:0] lzc(input logic [31:0] m);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  logic             ptr_r;  // 0 = A has priority, 1 = B
  logic             s1_valid_r;
  logic             s1_src_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [31:0]      s1_mant_r;
  logic [EXP_W-1:0] s1_exp_r;

  logic             out_valid_r;
  logic             out_src_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [31:0]      out_mant_r;
  logic [EXP_W-1:0] out_exp_r;
  logic [4:0]       out_lz_r;
  logic             out_zero_r;
  logic             out_uflow_r;

  logic             grant_a_s;
  logic             grant_b_s;
  logic             s2_load_s;
  logic             s1_free_s;
  logic             a_ready_s;
  logic             b_ready_s;
  logic             a_hs_s;
  logic             b_hs_s;
  logic [4:0]       lz_s;
  logic             zero_s;
  logic [31:0]      norm_mant_s;
  logic [EXP_W-1:0] norm_exp_s;
  logic             uflow_s;

  // Arbitration and pipeline advance; a grant never looks at its own port's valid.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (ptr_r == 1'b0) begin
      grant_a_s = 1'b1;
      grant_b_s = ~a_valid;
    end else begin
      grant_b_s = 1'b1;
      grant_a_s = ~b_valid;
    end
    s2_load_s = s1_valid_r & (~out_valid_r | out_ready);
    s1_free_s = ~s1_valid_r | s2_load_s;
    a_ready_s = rst_n & s1_free_s & grant_a_s;
    b_ready_s = rst_n & s1_free_s & grant_b_s;
    a_hs_s    = a_valid & a_ready_s;
    b_hs_s    = b_valid & b_ready_s;
  end

  // Normalize the S1 operand; underflow clamps the exponent but keeps the mantissa normalized.
  always_comb begin
    lz_s        = lzc(s1_mant_r);
    zero_s      = (s1_mant_r == 32'd0);
    norm_mant_s = s1_mant_r << lz_s;
    norm_exp_s  = {EXP_W{1'b0}};
    uflow_s     = 1'b0;
    if (zero_s) begin
      norm_exp_s = {EXP_W{1'b0}};
      uflow_s    = 1'b0;
    end else if ({5'd0, s1_exp_r} >= {{EXP_W{1'b0}}, lz_s}) begin
      norm_exp_s = s1_exp_r - EXP_W'(lz_s);
      uflow_s    = 1'b0;
    end else begin
      norm_exp_s = {EXP_W{1'b0}};
      uflow_s    = 1'b1;
    end
  end

  // Pointer, S1 capture and S2 output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= 1'b0;
      s1_valid_r  <= 1'b0;
      s1_src_r    <= 1'b0;
      s1_tag_r    <= {TAG_W{1'b0}};
      s1_mant_r   <= 32'd0;
      s1_exp_r    <= {EXP_W{1'b0}};
      out_valid_r <= 1'b0;
      out_src_r   <= 1'b0;
      out_tag_r   <= {TAG_W{1'b0}};
      out_mant_r  <= 32'd0;
      out_exp_r   <= {EXP_W{1'b0}};
      out_lz_r    <= 5'd0;
      out_zero_r  <= 1'b0;
      out_uflow_r <= 1'b0;
    end else begin
      if (a_hs_s) begin
        ptr_r      <= 1'b1;
        s1_valid_r <= 1'b1;
        s1_src_r   <= 1'b0;
        s1_tag_r   <= a_tag;
        s1_mant_r  <= a_mant;
        s1_exp_r   <= a_exp;
      end else if (b_hs_s) begin
        ptr_r      <= 1'b0;
        s1_valid_r <= 1'b1;
        s1_src_r   <= 1'b1;
        s1_tag_r   <= b_tag;
        s1_mant_r  <= b_mant;
        s1_exp_r   <= b_exp;
      end else if (s2_load_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end

      if (s2_load_s) begin
        out_valid_r <= 1'b1;
        out_src_r   <= s1_src_r;
        out_tag_r   <= s1_tag_r;
        out_mant_r  <= norm_mant_s;
        out_exp_r   <= norm_exp_s;
        out_lz_r    <= lz_s;
        out_zero_r  <= zero_s;
        out_uflow_r <= uflow_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign a_ready   = a_ready_s;
  assign b_ready   = b_ready_s;
  assign out_valid = out_valid_r;
  assign out_src   = out_src_r;
  assign out_tag   = out_tag_r;
  assign out_mant  = out_mant_r;
  assign out_exp   = out_exp_r;
  assign out_lz    = out_lz_r;
  assign out_zero  = out_zero_r;
  assign out_uflow = out_uflow_r;

endmodule
